// File: rtl/fetch_pkg.sv
// fetch_pkg: types and constants shared by the instruction fetch stage.
//   pc_t             32-bit fetch address
//   fetch_entry_t    {pc, insn} pair buffered for the core
//   EBREAK_INSN      word that stops fetching when FETCH_EBREAK_HALT_EN is defined
//   DEFAULT_RESET_PC first fetch address after reset
package fetch_pkg;

    typedef logic [31:0] pc_t;

    localparam logic [31:0] EBREAK_INSN      = 32'h0010_0073;
    localparam pc_t         DEFAULT_RESET_PC = 32'h8000_0000;

    typedef struct packed {
        pc_t         pc;
        logic [31:0] insn;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// fetch_if: handshake bundle around the fetch stage.
//   redirect_valid/redirect_pc      core -> fetch, PC change request
//   imem_req_valid/ready/addr       fetch -> memory request channel
//   imem_rsp_valid/data             memory -> fetch, in-order, no backpressure
//   inst_valid/ready/data/pc        fetch -> core instruction stream
// master = fetch unit side, slave = memory + core side.
interface fetch_if;
    import fetch_pkg::*;

    logic        redirect_valid;
    pc_t         redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    pc_t         imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    pc_t         inst_pc;

    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
        output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
        input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO, DEPTH entries (power of two), element type T.
//   push/push_data  write one entry (caller guarantees room, except push+pop when full)
//   pop             drop the head entry (ignored when empty)
//   flush           empty the FIFO; wins over push and pop in the same cycle
//   head            current head entry, combinational from storage
//   count           number of valid entries, 0..DEPTH
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  T                       push_data,
    output T                       head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    T              mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_pop;

    assign do_pop = pop && (count != '0);
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage ahead of the core.
//   clk, rst_n   clock and asynchronous active-low reset
//   bus          fetch_if.master: redirect in, imem request/response, instruction stream out
//   halted       fetch stopped on ebreak
// Optional feature: define FETCH_EBREAK_HALT_EN to stop issuing requests once an
// ebreak word enters the prefetch buffer; otherwise halted is tied low.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int  DEPTH    = 4,
    parameter pc_t RESET_PC = DEFAULT_RESET_PC
) (
    input  logic    clk,
    input  logic    rst_n,
    fetch_if.master bus,
    output logic    halted
);

    localparam int             CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]    CREDITS = (CW + 1)'(DEPTH);

    pc_t           fetch_pc;
    pc_t           rsp_pc;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW:0]   in_use;
    logic          accept;
    logic          buf_push;
    logic          buf_pop;
    fetch_entry_t  buf_head;
    fetch_entry_t  buf_in;

    // Buffered plus in-flight words never exceed DEPTH, so every response has a slot.
    assign in_use             = {1'b0, count} + {1'b0, outstanding};
    assign bus.imem_req_valid = !bus.redirect_valid && !halted && (in_use < CREDITS);
    assign bus.imem_req_addr  = fetch_pc;
    assign accept             = bus.imem_req_valid && bus.imem_req_ready;

    // Responses from before a redirect are swallowed until discard drains.
    assign buf_push = bus.imem_rsp_valid && !bus.redirect_valid && (discard == '0);
    assign buf_pop  = bus.inst_valid && bus.inst_ready;
    assign buf_in   = '{pc: rsp_pc, insn: bus.imem_rsp_data};

    // Pending-PC queue: its occupancy is the outstanding-request count. It is
    // never flushed because discarded responses still have to retire their PC.
    fetch_fifo #(.DEPTH(DEPTH), .T(pc_t)) u_pend (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept),
        .pop       (bus.imem_rsp_valid),
        .flush     (1'b0),
        .push_data (fetch_pc),
        .head      (rsp_pc),
        .count     (outstanding)
    );

    fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (buf_push),
        .pop       (buf_pop),
        .flush     (bus.redirect_valid),
        .push_data (buf_in),
        .head      (buf_head),
        .count     (count)
    );

    assign bus.inst_valid = (count != '0);
    assign bus.inst_data  = buf_head.insn;
    assign bus.inst_pc    = buf_head.pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  fetch_pc <= RESET_PC;
        else if (bus.redirect_valid) fetch_pc <= bus.redirect_pc;
        else if (accept)             fetch_pc <= fetch_pc + 32'd4;
    end

    // On redirect every request still in flight after this cycle is stale; a
    // response arriving in the redirect cycle itself is already dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  discard <= '0;
        else if (bus.redirect_valid) discard <= outstanding - CW'(bus.imem_rsp_valid);
        else if (bus.imem_rsp_valid && (discard != '0))
                                     discard <= discard - CW'(1);
    end

`ifdef FETCH_EBREAK_HALT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  halted <= 1'b0;
        else if (bus.redirect_valid) halted <= 1'b0;
        else if (buf_push && (bus.imem_rsp_data == EBREAK_INSN))
                                     halted <= 1'b1;
    end
`else
    assign halted = 1'b0;
`endif

endmodule
